// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for the MEM stage. The pipeline side (ex_stage
// and the write-back consumer) is the master; mem_stage is the slave.
interface mem_stage_if;
  logic [31:0] ALUoutputData_ex;
  logic [31:0] rtData_ex;
  logic [4:0]  RegFileWtAddr_ex;
  logic        wmem_ex;
  logic        wreg_ex;
  logic        Mem2Reg_ex;
  logic [31:0] RegFileWtData_mem;
  logic [4:0]  RegFileWtAddr_mem;
  logic        wreg_mem;
  logic        stall_mem;

  modport master (
    output ALUoutputData_ex, rtData_ex, RegFileWtAddr_ex,
           wmem_ex, wreg_ex, Mem2Reg_ex,
    input  RegFileWtData_mem, RegFileWtAddr_mem, wreg_mem, stall_mem
  );

  modport slave (
    input  ALUoutputData_ex, rtData_ex, RegFileWtAddr_ex,
           wmem_ex, wreg_ex, Mem2Reg_ex,
    output RegFileWtData_mem, RegFileWtAddr_mem, wreg_mem, stall_mem
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: word load/store to an internal data RAM with a fixed extra
// access latency, stalling upstream while an access is in flight, and
// registering the MEM/WB bundle.
//
//   state | meaning
//   IDLE  | new instruction evaluated; commits now unless a memory op must wait
//   WAIT  | memory op in flight; cnt counts remaining stall cycles, commits at 0
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         HAS_LAT  = (MEM_LATENCY > 0);
  localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              memop;
  logic [31:0]       rd_word;

  // Byte address -> word index; low two bits and bits above the RAM wrap.
  assign idx     = bus.ALUoutputData_ex[ADDR_W+1:2];
  assign memop   = bus.wmem_ex | bus.Mem2Reg_ex;
  assign rd_word = ram[idx];

  // Stall request: a fresh memory op with latency, or a WAIT with cycles left.
  always_comb begin
    bus.stall_mem = 1'b0;
    if (!reset) begin
      if (state == IDLE) bus.stall_mem = memop & HAS_LAT;
      else               bus.stall_mem = (cnt != 4'd0);
    end
  end

  // RAM write only on the commit edge; reset suppresses an in-flight store.
  always_ff @(posedge clk) begin
    if (!reset && !bus.stall_mem && bus.wmem_ex) ram[idx] <= bus.rtData_ex;
  end

  // Access sequencer and MEM/WB register; stall cycles emit bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      cnt                   <= 4'd0;
      bus.RegFileWtData_mem <= 32'd0;
      bus.RegFileWtAddr_mem <= 5'd0;
      bus.wreg_mem          <= 1'b0;
    end else if (bus.stall_mem) begin
      bus.wreg_mem <= 1'b0;
      if (state == IDLE) begin
        state <= WAIT;
        cnt   <= CNT_INIT;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else begin
      state                 <= IDLE;
      bus.RegFileWtData_mem <= bus.Mem2Reg_ex ? rd_word : bus.ALUoutputData_ex;
      bus.RegFileWtAddr_mem <= bus.RegFileWtAddr_ex;
      bus.wreg_mem          <= bus.wreg_ex;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances with latencies 0, 2 and 3, a table of
// directed vectors, a reset-during-wait sequence and random traffic checked
// against a word-array model of the data RAM.
module tb_mem_stage;
  logic clk;
  logic rst [3];
  logic [31:0] alu [3];
  logic [31:0] rt [3];
  logic [4:0]  wa [3];
  logic        wm [3];
  logic        wr [3];
  logic        m2r [3];
  logic [31:0] od [3];
  logic [4:0]  oa [3];
  logic        ow [3];
  logic        st [3];

  int total = 0;
  int bad = 0;
  int lat_of [3] = '{0, 2, 3};
  logic [31:0] mem_m [3][256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    mem_stage_if bus ();
    assign bus.ALUoutputData_ex = alu[g];
    assign bus.rtData_ex        = rt[g];
    assign bus.RegFileWtAddr_ex = wa[g];
    assign bus.wmem_ex          = wm[g];
    assign bus.wreg_ex          = wr[g];
    assign bus.Mem2Reg_ex       = m2r[g];
    assign od[g] = bus.RegFileWtData_mem;
    assign oa[g] = bus.RegFileWtAddr_mem;
    assign ow[g] = bus.wreg_mem;
    assign st[g] = bus.stall_mem;
    mem_stage #(.ADDR_W(8), .MEM_LATENCY(LAT)) dut (
      .clk  (clk),
      .reset(rst[g]),
      .bus  (bus)
    );
  end

  typedef struct {
    int          k;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wa;
    logic        wm;
    logic        wr;
    logic        m2r;
    logic [31:0] ed;
    logic        ew;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(int k, logic [31:0] a, logic [31:0] r, logic [4:0] w,
                              logic wmv, logic wrv, logic m2rv, logic [31:0] ed, logic ew);
    vec_t v;
    v.k = k; v.alu = a; v.rt = r; v.wa = w; v.wm = wmv; v.wr = wrv; v.m2r = m2rv;
    v.ed = ed; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic set_nop(input int k);
    alu[k] = 32'd0; rt[k] = 32'd0; wa[k] = 5'd0; wm[k] = 1'b0; wr[k] = 1'b0; m2r[k] = 1'b0;
  endtask

  // Applies one instruction and holds it until it commits; called #1 after an edge.
  task automatic run_op(input vec_t v, output logic [31:0] d, output logic [4:0] a,
                        output logic w, output int stalls);
    int k;
    bit done;
    logic s;
    k = v.k; done = 1'b0;
    alu[k] = v.alu; rt[k] = v.rt; wa[k] = v.wa; wm[k] = v.wm; wr[k] = v.wr; m2r[k] = v.m2r;
    stalls = 0; d = 32'd0; a = 5'd0; w = 1'b0;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      s = st[k];
      @(posedge clk); #1;
      if (s) begin
        stalls++;
        chk($sformatf("bubble_wreg dut%0d", k), 32'(ow[k]), 32'd0);
      end else begin
        d = od[k]; a = oa[k]; w = ow[k]; done = 1'b1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout dut%0d no commit within 40 cycles", k);
    end
    set_nop(k);
  endtask

  // Reference: a memory op occupies LAT stall cycles, then reads old word and writes new.
  task automatic model_op(input vec_t v, output logic [31:0] ed, output int es);
    int i;
    i = int'((v.alu >> 2) % 256);
    ed = v.m2r ? mem_m[v.k][i] : v.alu;
    if (v.wm) mem_m[v.k][i] = v.rt;
    es = (v.wm || v.m2r) ? lat_of[v.k] : 0;
  endtask

  initial begin
    logic [31:0] d, ed;
    logic [4:0] a;
    logic w;
    int s, es;
    vec_t v;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      set_nop(k);
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_data dut%0d", k), od[k], 32'd0);
      chk($sformatf("reset_addr dut%0d", k), 32'(oa[k]), 32'd0);
      chk($sformatf("reset_wreg dut%0d", k), 32'(ow[k]), 32'd0);
      chk($sformatf("reset_stall dut%0d", k), 32'(st[k]), 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(posedge clk); #1;

    // latency 0
    tbl.push_back(mk(0, 32'h1234, 32'h0, 5'd5, 0, 1, 0, 32'h1234, 1));
    tbl.push_back(mk(0, 32'h10, 32'hDEADBEEF, 5'd0, 1, 0, 0, 32'h10, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0, 5'd8, 0, 1, 1, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 32'h13, 32'h0, 5'd9, 0, 1, 1, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 32'h410, 32'h0, 5'd10, 0, 1, 1, 32'hDEADBEEF, 1));
    tbl.push_back(mk(0, 32'h10, 32'h0, 5'd11, 0, 0, 1, 32'hDEADBEEF, 0));
    // latency 2: back-to-back stores, loads, read-before-write
    tbl.push_back(mk(1, 32'h0, 32'hA0, 5'd1, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 32'h4, 32'hB0, 5'd2, 1, 0, 0, 32'h4, 0));
    tbl.push_back(mk(1, 32'h0, 32'h0, 5'd3, 0, 1, 1, 32'hA0, 1));
    tbl.push_back(mk(1, 32'h4, 32'h0, 5'd4, 0, 1, 1, 32'hB0, 1));
    tbl.push_back(mk(1, 32'h8, 32'h11, 5'd0, 1, 0, 0, 32'h8, 0));
    tbl.push_back(mk(1, 32'h8, 32'h22, 5'd4, 1, 1, 1, 32'h11, 1));
    tbl.push_back(mk(1, 32'h8, 32'h0, 5'd6, 0, 1, 1, 32'h22, 1));
    tbl.push_back(mk(1, 32'h99, 32'h0, 5'd12, 0, 1, 0, 32'h99, 1));
    // latency 3
    tbl.push_back(mk(2, 32'h20, 32'h55, 5'd0, 1, 0, 0, 32'h20, 0));
    tbl.push_back(mk(2, 32'h20, 32'h0, 5'd3, 0, 1, 1, 32'h55, 1));
    tbl.push_back(mk(2, 32'hCAFE, 32'h0, 5'd13, 0, 1, 0, 32'hCAFE, 1));
    tbl.push_back(mk(2, 32'h30, 32'h0, 5'd0, 1, 0, 0, 32'h30, 0));
    tbl.push_back(mk(2, 32'h77, 32'h0, 5'd7, 0, 1, 0, 32'h77, 1));

    foreach (tbl[i]) begin
      run_op(tbl[i], d, a, w, s);
      model_op(tbl[i], ed, es);
      chk($sformatf("vec%0d stalls", i), 32'(s), 32'(es));
      chk($sformatf("vec%0d data", i), d, tbl[i].ed);
      chk($sformatf("vec%0d addr", i), 32'(a), 32'(tbl[i].wa));
      chk($sformatf("vec%0d wreg", i), 32'(w), 32'(tbl[i].ew));
    end

    // Reset during the second stall cycle of a store on the latency-3 instance.
    alu[2] = 32'h30; rt[2] = 32'hAAAA; wa[2] = 5'd0; wm[2] = 1'b1; wr[2] = 1'b0; m2r[2] = 1'b0;
    #1;
    chk("abort first_stall", 32'(st[2]), 32'd1);
    @(posedge clk); #1;
    chk("abort second_stall", 32'(st[2]), 32'd1);
    rst[2] = 1'b1;
    #1;
    chk("abort data", od[2], 32'd0);
    chk("abort addr", 32'(oa[2]), 32'd0);
    chk("abort wreg", 32'(ow[2]), 32'd0);
    chk("abort stall", 32'(st[2]), 32'd0);
    @(posedge clk); #1;
    set_nop(2);
    #2;
    rst[2] = 1'b0;
    @(posedge clk); #1;
    v = mk(2, 32'h30, 32'h0, 5'd14, 0, 1, 1, 32'h0, 1);
    run_op(v, d, a, w, s);
    chk("abort reload stalls", 32'(s), 32'd3);
    chk("abort reload data", d, 32'h0);
    chk("abort reload wreg", 32'(w), 32'd1);

    // Random traffic against the model, on a 16-word window with address aliasing.
    for (int k = 0; k < 3; k++) begin
      for (int wd = 0; wd < 16; wd++) begin
        v = mk(k, 32'(wd) << 2, $urandom, 5'd0, 1, 0, 0, 32'h0, 0);
        run_op(v, d, a, w, s);
        model_op(v, ed, es);
        chk($sformatf("init dut%0d w%0d stalls", k, wd), 32'(s), 32'(es));
      end
      for (int n = 0; n < 30; n++) begin
        int kind;
        logic [31:0] addr;
        kind = $urandom_range(0, 3);
        addr = ($urandom & ~32'h3FF) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        v = mk(k, (kind == 0) ? $urandom : addr, $urandom, 5'($urandom_range(0, 31)),
               (kind == 1 || kind == 3), 1'($urandom_range(0, 1)),
               (kind == 2 || kind == 3), 32'h0, 0);
        run_op(v, d, a, w, s);
        model_op(v, ed, es);
        chk($sformatf("rnd dut%0d #%0d stalls", k, n), 32'(s), 32'(es));
        chk($sformatf("rnd dut%0d #%0d data", k, n), d, ed);
        chk($sformatf("rnd dut%0d #%0d addr", k, n), 32'(a), 32'(v.wa));
        chk($sformatf("rnd dut%0d #%0d wreg", k, n), 32'(w), 32'(v.wr));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of ex_stage.
- Consumes the EX/MEM pipeline register outputs: ALU result, store data, write-back address and control bits.
- Performs word load/store to an internal data RAM with a configurable access latency; stalls upstream while an access is in flight.
- Registers the MEM/WB bundle (selected write-back data, address, write enable) for the write-back stage.

Parameters:
- ADDR_W, 8, log2 of data RAM depth in 32-bit words (default 256 words).
- MEM_LATENCY, 0, extra cycles per load/store, range 0..15; 0 means single-cycle access with no stall.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ALUoutputData_ex  input  32  ALU result: byte address for load/store, or write-back value.
- rtData_ex  input  32  store data.
- RegFileWtAddr_ex  input  5  destination register.
- wmem_ex  input  1  store request.
- wreg_ex  input  1  register write enable.
- Mem2Reg_ex  input  1  1 = load (write-back data from RAM), 0 = ALU result.
- RegFileWtData_mem  output  32  registered write-back data.
- RegFileWtAddr_mem  output  5  registered destination register.
- wreg_mem  output  1  registered register write enable.
- stall_mem  output  1  combinational; 1 = hold all upstream pipeline registers and PC.

Behaviour:
- Reset (async, active-high):
  - Outputs RegFileWtData_mem=0, RegFileWtAddr_mem=0, wreg_mem=0.
  - State=IDLE, cnt=0; stall_mem=0 while reset is high.
  - RAM contents are not reset.
- Addressing:
  - word index = ALUoutputData_ex[ADDR_W+1:2].
  - Bits [1:0] are ignored (word access only).
  - Upper bits are ignored, so addresses wrap modulo RAM size.
- Memory op: memop = wmem_ex | Mem2Reg_ex.
- Commit (single clock edge):
  - If wmem_ex: RAM[idx] <= rtData_ex.
  - RegFileWtData_mem <= Mem2Reg_ex ? RAM[idx] : ALUoutputData_ex. RAM read is read-before-write, so wmem_ex=Mem2Reg_ex=1 returns the old word.
  - RegFileWtAddr_mem <= RegFileWtAddr_ex; wreg_mem <= wreg_ex.
- FSM, states IDLE and WAIT, cnt 4 bits:
  - IDLE, !memop, or memop with MEM_LATENCY=0: stall_mem=0; commit at edge.
  - IDLE, memop, MEM_LATENCY>0: stall_mem=1; at edge: state<=WAIT, cnt<=MEM_LATENCY-1, wreg_mem<=0 (bubble), no RAM write.
  - WAIT, cnt!=0: stall_mem=1; cnt<=cnt-1; bubble (wreg_mem<=0); no RAM write.
  - WAIT, cnt==0: stall_mem=0; commit at edge; state<=IDLE.
- Stall timing: exactly MEM_LATENCY stall cycles per memory op; result visible at the outputs MEM_LATENCY+1 edges after the op first appears.
- Upstream contract:
  - While stall_mem=1, ex_stage and earlier stages hold their registers, so the *_ex inputs are stable.
  - An op following directly after a commit starts a new IDLE evaluation on the next cycle (back-to-back ops each stall in full).
- Non-memory instructions never stall and pass through with 1-cycle latency.
- Reset mid-WAIT: the pending access is aborted; no RAM write occurs; state returns to IDLE.
- wreg_ex=0 with Mem2Reg_ex=1 still performs the read and stalls; wreg_mem=0 at commit.

Test Plan:
- MEM_LATENCY=0, ALU op (ALUoutputData_ex=0x1234, addr 5, wreg 1) -> next edge RegFileWtData_mem=0x1234, RegFileWtAddr_mem=5, wreg_mem=1, stall_mem never 1.
- MEM_LATENCY=0:
  - Store 0xDEADBEEF to address 0x10.
  - Then load from 0x10 into r8 -> RegFileWtData_mem=0xDEADBEEF, wreg_mem=1, RegFileWtAddr_mem=8.
  - Address 0x13 reads the same word; address 0x410 (ADDR_W=8) wraps to the same word.
- MEM_LATENCY=3, load from 0x20 holding 0x55 -> stall_mem high exactly 3 cycles; wreg_mem=0 during them; 4th edge RegFileWtData_mem=0x55, wreg_mem=1.
- MEM_LATENCY=2:
  - Two back-to-back stores to 0x0 and 0x4 -> 2 stall cycles each, both words written, no write during stall cycles.
  - Simultaneous wmem_ex=Mem2Reg_ex=1 to 0x8 (old 0x11, new 0x22) -> output 0x11, RAM now 0x22.
- MEM_LATENCY=3: assert reset during the 2nd stall cycle of a store of 0xAAAA to 0x30 (old 0x0) -> outputs 0 immediately, stall_mem=0, later load of 0x30 returns 0x0.
